// File: rtl/fp_mul_norm_round_pipe.sv
// fp_mul_norm_round_pipe
// Normalise, round-to-nearest-even and pack stage of the floating-point
// multiplier. It takes the raw mantissa product and the unbiased exponent
// sum and emits a packed {sign, biased exponent, fraction} word. Results
// that overflow become infinity, results that underflow are flushed to
// zero, and errored items can be forced to a canonical NaN. The output
// pipeline is 1 or 2 stages deep, uses valid/ready handshakes, and stalls
// every stage together when the output is held.
//
// Ports
//   clk, rstn              clock, synchronous active-low reset
//   in_valid / in_ready    input handshake (in_ready is combinational)
//   in_sign                product sign
//   in_man  [PW-1:0]       mantissa product 1.x*1.y, binary point below bit PW-2
//   in_exp  [EXP_W+1:0]    signed unbiased exponent sum
//   in_side [SIDE_W-1:0]   sideband, carried unchanged
//   in_err                 upstream error
//   out_valid / out_ready  output handshake
//   out_float              {sign, biased exponent, fraction}
//   out_side               sideband aligned with out_float
//   out_err                error carried through
//   out_ovf                result saturated to infinity
//   out_unf                result flushed to zero
module fp_mul_norm_round_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int BIAS    = 127,
    parameter int STAGES  = 2,
    parameter int SIDE_W  = 32,
    parameter int ERR_NAN = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [2*MAN_W+1:0]   in_man,
    input  logic [EXP_W+1:0]     in_exp,
    input  logic [SIDE_W-1:0]    in_side,
    input  logic                 in_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_float,
    output logic [SIDE_W-1:0]    out_side,
    output logic                 out_err,
    output logic                 out_ovf,
    output logic                 out_unf
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int FW = 1 + EXP_W + MAN_W;
    // Two bits of headroom beyond the exponent input so that the normalise
    // and rounding increments plus the bias can never wrap before the
    // range checks.
    localparam int BW = EXP_W + 4;

    localparam logic signed [BW-1:0] BIAS_S  = BW'(BIAS);
    localparam logic signed [BW-1:0] BE_MAX  = {{(BW-EXP_W){1'b0}}, {EXP_W{1'b1}}};
    localparam logic signed [BW-1:0] BE_ZERO = {BW{1'b0}};

    // Packs a rounded result into {word, ovf, unf}. Error outranks zero,
    // which outranks overflow, which outranks underflow.
    function automatic logic [FW+1:0] pack_fn(
        input logic                   sign,
        input logic [MAN_W-1:0]       frac,
        input logic signed [BW-1:0]   be,
        input logic                   zero,
        input logic                   err
    );
        logic [FW-1:0] word;
        logic          ovf;
        logic          unf;
        if (err && (ERR_NAN != 0)) begin
            word = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            ovf  = 1'b0;
            unf  = 1'b0;
        end else if (zero) begin
            word = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            ovf  = 1'b0;
            unf  = 1'b0;
        end else if (be >= BE_MAX) begin
            word = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf  = 1'b1;
            unf  = 1'b0;
        end else if (be <= BE_ZERO) begin
            word = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            ovf  = 1'b0;
            unf  = 1'b1;
        end else begin
            word = {sign, be[EXP_W-1:0], frac};
            ovf  = 1'b0;
            unf  = 1'b0;
        end
        return {word, ovf, unf};
    endfunction

    // ------------------------------------------------------------------
    // Handshake: every stage advances together whenever the output slot
    // is empty or being drained.
    // ------------------------------------------------------------------
    logic out_valid_r;
    logic en_s;

    assign en_s     = out_ready | ~out_valid_r;
    assign in_ready = en_s;

    // ------------------------------------------------------------------
    // Normalise and round (combinational, from the input item)
    // ------------------------------------------------------------------
    logic                 norm_s;
    logic                 zero_s;
    logic [MAN_W-1:0]     frac_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic                 round_up_s;
    logic [MAN_W:0]       frac_inc_s;
    logic [MAN_W-1:0]     frac_rnd_s;
    logic                 carry_s;
    logic signed [BW-1:0] exp_ext_s;
    logic signed [BW-1:0] norm_ext_s;
    logic signed [BW-1:0] carry_ext_s;
    logic signed [BW-1:0] be_s;

    // A set top bit means the product is in [2,4): the fraction window
    // starts one bit higher and the exponent gains one.
    assign norm_s = in_man[PW-1];
    assign zero_s = (in_man[PW-1 -: 2] == 2'b00);

    // Select fraction, guard and sticky from the window chosen by norm_s.
    always_comb begin
        frac_s   = {MAN_W{1'b0}};
        guard_s  = 1'b0;
        sticky_s = 1'b0;
        if (norm_s) begin
            frac_s   = in_man[PW-2 -: MAN_W];
            guard_s  = in_man[PW-2-MAN_W];
            sticky_s = |in_man[PW-3-MAN_W:0];
        end else begin
            frac_s   = in_man[PW-3 -: MAN_W];
            guard_s  = in_man[PW-3-MAN_W];
            sticky_s = |in_man[PW-4-MAN_W:0];
        end
    end

    assign round_up_s = guard_s & (sticky_s | frac_s[0]);
    assign frac_inc_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, 1'b1};

    // Apply the nearest-even increment; an all-ones fraction wraps to zero
    // and carries into the exponent.
    always_comb begin
        frac_rnd_s = frac_s;
        carry_s    = 1'b0;
        if (round_up_s) begin
            frac_rnd_s = frac_inc_s[MAN_W-1:0];
            carry_s    = frac_inc_s[MAN_W];
        end else begin
            frac_rnd_s = frac_s;
            carry_s    = 1'b0;
        end
    end

    assign exp_ext_s   = {{2{in_exp[EXP_W+1]}}, in_exp};
    assign norm_ext_s  = {{(BW-1){1'b0}}, norm_s};
    assign carry_ext_s = {{(BW-1){1'b0}}, carry_s};
    assign be_s        = exp_ext_s + norm_ext_s + carry_ext_s + BIAS_S;

    // ------------------------------------------------------------------
    // Output register (shared by both depths)
    // ------------------------------------------------------------------
    logic [FW+1:0]     pk_s;
    logic              pk_valid_s;
    logic [SIDE_W-1:0] pk_side_s;
    logic              pk_err_s;
    logic [FW-1:0]     out_float_r;
    logic [SIDE_W-1:0] out_side_r;
    logic              out_err_r;
    logic              out_ovf_r;
    logic              out_unf_r;

    generate
        if (STAGES == 1) begin : g_one
            assign pk_s       = pack_fn(in_sign, frac_rnd_s, be_s, zero_s, in_err);
            assign pk_valid_s = in_valid;
            assign pk_side_s  = in_side;
            assign pk_err_s   = in_err;
        end else begin : g_two
            logic                 s1_valid_r;
            logic                 s1_sign_r;
            logic [MAN_W-1:0]     s1_frac_r;
            logic signed [BW-1:0] s1_be_r;
            logic                 s1_zero_r;
            logic                 s1_err_r;
            logic [SIDE_W-1:0]    s1_side_r;

            // Stage 1: hold the normalised and rounded fields of the accepted item.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    s1_valid_r <= 1'b0;
                    s1_sign_r  <= 1'b0;
                    s1_frac_r  <= {MAN_W{1'b0}};
                    s1_be_r    <= {BW{1'b0}};
                    s1_zero_r  <= 1'b0;
                    s1_err_r   <= 1'b0;
                    s1_side_r  <= {SIDE_W{1'b0}};
                end else if (en_s) begin
                    s1_valid_r <= in_valid;
                    s1_sign_r  <= in_sign;
                    s1_frac_r  <= frac_rnd_s;
                    s1_be_r    <= be_s;
                    s1_zero_r  <= zero_s;
                    s1_err_r   <= in_err;
                    s1_side_r  <= in_side;
                end
            end

            assign pk_s       = pack_fn(s1_sign_r, s1_frac_r, s1_be_r, s1_zero_r, s1_err_r);
            assign pk_valid_s = s1_valid_r;
            assign pk_side_s  = s1_side_r;
            assign pk_err_s   = s1_err_r;
        end
    endgenerate

    // Final stage: packed word, sideband and flags, held while stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_float_r <= {FW{1'b0}};
            out_side_r  <= {SIDE_W{1'b0}};
            out_err_r   <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_unf_r   <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= pk_valid_s;
            out_float_r <= pk_s[FW+1:2];
            out_side_r  <= pk_side_s;
            out_err_r   <= pk_err_s;
            out_ovf_r   <= pk_s[1];
            out_unf_r   <= pk_s[0];
        end
    end

    assign out_valid = out_valid_r;
    assign out_float = out_float_r;
    assign out_side  = out_side_r;
    assign out_err   = out_err_r;
    assign out_ovf   = out_ovf_r;
    assign out_unf   = out_unf_r;

endmodule

// File: tb/tb_fp_mul_norm_round_pipe.sv
// Scoreboard bench for fp_mul_norm_round_pipe. DUT A uses the default
// single-precision, 2-stage configuration; DUT B is the 1-stage
// half-precision-like variant (EXP_W=5, MAN_W=10, BIAS=15).
module tb_fp_mul_norm_round_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        a_in_valid, a_in_ready, a_in_sign, a_in_err;
    logic [47:0] a_in_man;
    logic [9:0]  a_in_exp;
    logic [31:0] a_in_side;
    logic        a_out_valid, a_out_ready, a_out_err, a_out_ovf, a_out_unf;
    logic [31:0] a_out_float, a_out_side;

    logic        b_in_valid, b_in_ready, b_in_sign, b_in_err;
    logic [21:0] b_in_man;
    logic [6:0]  b_in_exp;
    logic [7:0]  b_in_side;
    logic        b_out_valid, b_out_ready, b_out_err, b_out_ovf, b_out_unf;
    logic [15:0] b_out_float;
    logic [7:0]  b_out_side;

    fp_mul_norm_round_pipe dut_a (
        .clk(clk), .rstn(rstn),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sign(a_in_sign),
        .in_man(a_in_man), .in_exp(a_in_exp), .in_side(a_in_side), .in_err(a_in_err),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_float(a_out_float),
        .out_side(a_out_side), .out_err(a_out_err), .out_ovf(a_out_ovf), .out_unf(a_out_unf)
    );

    fp_mul_norm_round_pipe #(
        .EXP_W(5), .MAN_W(10), .BIAS(15), .STAGES(1), .SIDE_W(8), .ERR_NAN(1)
    ) dut_b (
        .clk(clk), .rstn(rstn),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sign(b_in_sign),
        .in_man(b_in_man), .in_exp(b_in_exp), .in_side(b_in_side), .in_err(b_in_err),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_float(b_out_float),
        .out_side(b_out_side), .out_err(b_out_err), .out_ovf(b_out_ovf), .out_unf(b_out_unf)
    );

    typedef struct {
        logic [31:0] f;
        logic [31:0] side;
        logic        err;
        logic        ovf;
        logic        unf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: treat the product as an integer, drop the bits
    // below the fraction with round-half-even on the exact remainder,
    // renormalise on carry, then apply bias and range limits.
    function automatic void ref_model(input int ew, input int mw, input int bias,
                                      input bit sign, input longint unsigned man,
                                      input int ex, input bit err,
                                      output longint unsigned f, output bit ovf, output bit unf);
        int pw, k, shift, be;
        longint unsigned q, rem, half, ones_e, ones_m, sgn;
        pw = 2 * mw + 2;
        ovf = 1'b0;
        unf = 1'b0;
        ones_e = (64'd1 << ew) - 64'd1;
        ones_m = (64'd1 << mw) - 64'd1;
        sgn = sign ? (64'd1 << (ew + mw)) : 64'd0;
        if (err) begin
            f = (ones_e << mw) | ones_m;
            return;
        end
        if (man < (64'd1 << (pw - 2))) begin
            f = sgn;
            return;
        end
        k = ((man >> (pw - 1)) != 64'd0) ? 1 : 0;
        shift = pw - 2 - mw + k;
        q = man >> shift;
        rem = man & ((64'd1 << shift) - 64'd1);
        half = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && (q & 64'd1) != 64'd0)) q = q + 64'd1;
        be = ex + k + bias;
        if (q >= (64'd1 << (mw + 1))) begin
            q = q >> 1;
            be = be + 1;
        end
        if (be >= int'(ones_e)) begin
            ovf = 1'b1;
            f = sgn | (ones_e << mw);
        end else if (be <= 0) begin
            unf = 1'b1;
            f = sgn;
        end else begin
            f = sgn | (longint'(be) << mw) | (q & ones_m);
        end
    endfunction

    task automatic send_a(input bit s, input logic [47:0] m, input int e,
                          input logic [31:0] sd, input bit er, input bit lat);
        exp_t x;
        longint unsigned f;
        bit ov, un, done;
        int n;
        ref_model(8, 23, 127, s, {16'h0000, m}, e, er, f, ov, un);
        x.f = f[31:0]; x.side = sd; x.err = er; x.ovf = ov; x.unf = un; x.lat = lat;
        a_in_valid = 1'b1; a_in_sign = s; a_in_man = m; a_in_exp = e[9:0];
        a_in_side = sd; a_in_err = er;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (a_in_ready) begin
                done = 1'b1;
            end else if (n > 200) begin
                errors++; checks++;
                $display("FAIL a_accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
                done = 1'b1;
            end else begin
                n++;
                @(posedge clk); #1;
            end
        end
        if (n <= 200) begin
            x.acc = cyc;
            qa.push_back(x);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input bit s, input logic [21:0] m, input int e,
                          input logic [7:0] sd, input bit er);
        exp_t x;
        longint unsigned f;
        bit ov, un;
        ref_model(5, 10, 15, s, {42'h0, m}, e, er, f, ov, un);
        x.f = {16'h0000, f[15:0]}; x.side = {24'h0, sd}; x.err = er; x.ovf = ov;
        x.unf = un; x.lat = 1'b1;
        b_in_valid = 1'b1; b_in_sign = s; b_in_man = m; b_in_exp = e[6:0];
        b_in_side = sd; b_in_err = er;
        @(negedge clk);
        chk("b_in_ready", {63'h0, b_in_ready}, 64'd1);
        x.acc = cyc;
        qb.push_back(x);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d/%0d items still pending, expected 0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor A: scoreboard compare on every transfer and stability while stalled.
    bit          hold_a = 1'b0;
    logic [31:0] hold_f, hold_s;
    logic [2:0]  hold_fl;
    always @(negedge clk) begin
        exp_t x;
        if (!rstn) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                chk("a_hold_valid", {63'h0, a_out_valid}, 64'd1);
                chk("a_hold_float", {32'h0, a_out_float}, {32'h0, hold_f});
                chk("a_hold_side", {32'h0, a_out_side}, {32'h0, hold_s});
                chk("a_hold_flags", {61'h0, a_out_err, a_out_ovf, a_out_unf}, {61'h0, hold_fl});
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL a_unexpected: output %0h side %0h, expected none", a_out_float, a_out_side);
                end else begin
                    x = qa.pop_front();
                    chk("a_float", {32'h0, a_out_float}, {32'h0, x.f});
                    chk("a_side", {32'h0, a_out_side}, {32'h0, x.side});
                    chk("a_flags", {61'h0, a_out_err, a_out_ovf, a_out_unf}, {61'h0, x.err, x.ovf, x.unf});
                    if (x.lat) chk("a_latency", 64'(cyc - x.acc), 64'd2);
                end
            end
            hold_a  = a_out_valid && !a_out_ready;
            hold_f  = a_out_float;
            hold_s  = a_out_side;
            hold_fl = {a_out_err, a_out_ovf, a_out_unf};
        end
    end

    // Monitor B: scoreboard compare with 1-cycle latency.
    always @(negedge clk) begin
        exp_t y;
        if (rstn && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                errors++; checks++;
                $display("FAIL b_unexpected: output %0h, expected none", b_out_float);
            end else begin
                y = qb.pop_front();
                chk("b_float", {48'h0, b_out_float}, {32'h0, y.f});
                chk("b_side", {56'h0, b_out_side}, {32'h0, y.side});
                chk("b_flags", {61'h0, b_out_err, b_out_ovf, b_out_unf}, {61'h0, y.err, y.ovf, y.unf});
                if (y.lat) chk("b_latency", 64'(cyc - y.acc), 64'd1);
            end
        end
    end

    initial begin
        logic [63:0] r;
        logic [47:0] m;
        logic [21:0] mb;
        int e, mode;
        a_in_valid = 1'b0; a_in_sign = 1'b0; a_in_man = 48'h0; a_in_exp = 10'h0;
        a_in_side = 32'h0; a_in_err = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sign = 1'b0; b_in_man = 22'h0; b_in_exp = 7'h0;
        b_in_side = 8'h0; b_in_err = 1'b0; b_out_ready = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_a_valid", {63'h0, a_out_valid}, 64'd0);
        chk("rst_a_float", {32'h0, a_out_float}, 64'd0);
        chk("rst_a_side", {32'h0, a_out_side}, 64'd0);
        chk("rst_a_flags", {61'h0, a_out_err, a_out_ovf, a_out_unf}, 64'd0);
        chk("rst_a_in_ready", {63'h0, a_in_ready}, 64'd1);
        chk("rst_b_valid", {63'h0, b_out_valid}, 64'd0);
        chk("rst_b_float", {48'h0, b_out_float}, 64'd0);
        @(posedge clk); #1;

        // Directed: normalise, rounding, carry, exceptions and exponent boundaries.
        send_a(1'b0, 48'h900000000000, 0, 32'hD0000001, 1'b0, 1'b1);
        send_a(1'b0, 48'h400000400000, 0, 32'hD0000002, 1'b0, 1'b1);
        send_a(1'b0, 48'h400000C00000, 0, 32'hD0000003, 1'b0, 1'b1);
        send_a(1'b0, 48'h7FFFFFC00001, 0, 32'hD0000004, 1'b0, 1'b1);
        send_a(1'b1, 48'hFFFFFF800001, 0, 32'hD0000005, 1'b0, 1'b1);
        send_a(1'b0, 48'h400000000000, 128, 32'hD0000006, 1'b0, 1'b1);
        send_a(1'b0, 48'h400000000000, -127, 32'hD0000007, 1'b0, 1'b1);
        send_a(1'b1, 48'h000000000000, 5, 32'hD0000008, 1'b0, 1'b1);
        send_a(1'b1, 48'h900000000000, 3, 32'hD0000009, 1'b1, 1'b1);
        send_a(1'b0, 48'h400000000000, 127, 32'hD000000A, 1'b0, 1'b1);
        send_a(1'b0, 48'h400000000000, -126, 32'hD000000B, 1'b0, 1'b1);
        send_a(1'b0, 48'h800000000000, 127, 32'hD000000C, 1'b0, 1'b1);
        send_a(1'b0, 48'h7FFFFFC00001, 127, 32'hD000000D, 1'b0, 1'b1);
        send_a(1'b0, 48'h200000000000, 0, 32'hD000000E, 1'b0, 1'b1);
        drain();

        // Backpressure: 6 items, output stalled on cycles 3-5.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_a(i[0], 48'h600000000000 + 48'(i * 48'h1234567), i, 32'hB0 + 32'(i), 1'b0, 1'b0);
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    a_out_ready = !(j >= 3 && j <= 5);
                    @(negedge clk);
                    if (j >= 3 && j <= 5) chk("bp_in_ready", {63'h0, a_in_ready}, 64'd0);
                    @(posedge clk); #1;
                end
                a_out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two items in flight; neither may ever appear.
        a_out_ready = 1'b0;
        send_a(1'b0, 48'h500000000000, 1, 32'hDEAD0001, 1'b0, 1'b0);
        send_a(1'b0, 48'h500000000000, 2, 32'hDEAD0002, 1'b0, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_valid", {63'h0, a_out_valid}, 64'd0);
        chk("rst_mid_float", {32'h0, a_out_float}, 64'd0);
        qa.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", {63'h0, a_in_ready}, 64'd1);
        @(posedge clk); #1;
        send_a(1'b1, 48'h900000000000, 10, 32'hA5A5A5A5, 1'b0, 1'b1);
        drain();

        // Random stream with random output backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    r = {$urandom(), $urandom()};
                    m = r[47:0];
                    mode = int'($urandom_range(0, 7));
                    e = int'($urandom_range(0, 300)) - 150;
                    if (mode == 0) m = {2'b00, m[45:0]};
                    else if (m[47:46] == 2'b00) m[46] = 1'b1;
                    if (mode == 1) m[20:0] = 21'h0;
                    if (mode == 2) m[22:0] = 23'h400000;
                    if (mode == 3) e = 127 + int'($urandom_range(0, 3)) - 2;
                    if (mode == 4) e = -126 + int'($urandom_range(0, 3)) - 2;
                    send_a(r[63], m, e, $urandom(), ($urandom_range(0, 15) == 0), 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    a_out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                a_out_ready = 1'b1;
            end
        join
        drain();

        // DUT B: 1-stage reduced-width variant.
        send_b(1'b0, 22'h240000, 0, 8'h11, 1'b0);
        send_b(1'b0, 22'h100000, 16, 8'h12, 1'b0);
        send_b(1'b1, 22'h100000, -15, 8'h13, 1'b0);
        send_b(1'b0, 22'h1FFE01, 0, 8'h14, 1'b0);
        send_b(1'b0, 22'h240000, 0, 8'h15, 1'b1);
        for (int i = 0; i < 40; i++) begin
            mb = 22'($urandom());
            if (mb[21:20] == 2'b00 && i[1:0] != 2'b00) mb[20] = 1'b1;
            send_b(mb[0], mb, int'($urandom_range(0, 40)) - 20, 8'($urandom()), ($urandom_range(0, 9) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
